// File: rtl/diwall_pkg.sv
// Shared types and constants for the HPM window sampler.
// Holds FSM states, detector alert classes and HPM array sizing.
package diwall_pkg;

  localparam int HPM_W = 64;
  localparam int HPM_N = 2;

  localparam logic [1:0] ALERT_LEG = 2'b00;
  localparam logic [1:0] ALERT_SBO = 2'b10;
  localparam logic [1:0] ALERT_HBO = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    REQ,
    WAIT
  } state_e;

endpackage

// File: rtl/diwall_window_timer.sv
// Window cycle counter with a single-cycle window-end pulse.
// Counts only while run is high; clr restarts the window.
module diwall_window_timer #(
  parameter int unsigned WINDOW_CYCLES = 1000
) (
  input  logic clk_h,
  input  logic rst_h,
  input  logic clr,
  input  logic run,
  output logic wend
);

  localparam logic [31:0] LAST = 32'(WINDOW_CYCLES - 1);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  assign wend = run && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = wend ? '0 : cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_h or negedge rst_h) begin
    if (!rst_h) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hpm_window_sampler.sv
// Samples HPM event deltas per window and hands them to a detector.
// Tracks detector verdicts, attack interrupt and sticky error flags.
module hpm_window_sampler
  import diwall_pkg::*;
#(
  parameter int unsigned WINDOW_CYCLES  = 1000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                        clk_h,
  input  logic                        rst_h,
  input  logic                        en,
  input  logic [HPM_N-1:0][HPM_W-1:0] hpm_raw,
  output logic [HPM_N-1:0][HPM_W-1:0] HPM,
  output logic                        enableD,
  input  logic                        endD,
  input  logic [1:0]                  alert,
  output logic [1:0]                  alert_q,
  output logic                        irq,
  input  logic                        irq_ack,
  output logic [31:0]                 attack_cnt,
  output logic                        timeout_err,
  output logic                        overrun_err
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e state_q, state_d;
  logic [HPM_N-1:0][HPM_W-1:0] base_q, base_d;
  logic [HPM_N-1:0][HPM_W-1:0] hpm_q, hpm_d;
  logic [1:0]  alert_cap_q, alert_cap_d;
  logic        irq_q, irq_d;
  logic [31:0] atk_q, atk_d;
  logic        tmo_q, tmo_d;
  logic        ovr_q, ovr_d;
  logic [7:0]  tcnt_q, tcnt_d;
  logic        clr;
  logic        run;
  logic        wend;

  assign run = en && (state_q != IDLE);

  diwall_window_timer #(
    .WINDOW_CYCLES(WINDOW_CYCLES)
  ) u_timer (
    .clk_h(clk_h),
    .rst_h(rst_h),
    .clr  (clr),
    .run  (run),
    .wend (wend)
  );

  assign HPM         = hpm_q;
  assign enableD     = en && (state_q == REQ);
  assign alert_q     = alert_cap_q;
  assign irq         = irq_q;
  assign attack_cnt  = atk_q;
  assign timeout_err = tmo_q;
  assign overrun_err = ovr_q;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    hpm_d       = hpm_q;
    alert_cap_d = alert_cap_q;
    irq_d       = irq_q;
    atk_d       = atk_q;
    tmo_d       = tmo_q;
    ovr_d       = ovr_q;
    tcnt_d      = tcnt_q;
    clr         = 1'b0;
    if (irq_ack) irq_d = 1'b0;
    if (!en) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = COUNT;
          base_d  = hpm_raw;
          clr     = 1'b1;
        end
        COUNT: begin
          if (wend) begin
            for (int i = 0; i < HPM_N; i++)
              hpm_d[i] = hpm_raw[i] - base_q[i];
            base_d  = hpm_raw;
            state_d = REQ;
          end
        end
        REQ: begin
          state_d = WAIT;
          tcnt_d  = '0;
          if (wend) begin
            base_d = hpm_raw;
            ovr_d  = 1'b1;
          end
        end
        WAIT: begin
          if (wend) begin
            base_d = hpm_raw;
            ovr_d  = 1'b1;
          end
          // A verdict arriving on the last allowed cycle still counts.
          if (endD) begin
            alert_cap_d = alert;
            state_d     = COUNT;
            if (alert != ALERT_LEG) begin
              irq_d = 1'b1;
              if (atk_q != '1) atk_d = atk_q + 32'd1;
            end
          end else if (tcnt_q == TO_LAST) begin
            tmo_d   = 1'b1;
            state_d = COUNT;
          end else begin
            tcnt_d = tcnt_q + 8'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_h or negedge rst_h) begin
    if (!rst_h) begin
      state_q     <= IDLE;
      base_q      <= '0;
      hpm_q       <= '0;
      alert_cap_q <= ALERT_LEG;
      irq_q       <= 1'b0;
      atk_q       <= '0;
      tmo_q       <= 1'b0;
      ovr_q       <= 1'b0;
      tcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      hpm_q       <= hpm_d;
      alert_cap_q <= alert_cap_d;
      irq_q       <= irq_d;
      atk_q       <= atk_d;
      tmo_q       <= tmo_d;
      ovr_q       <= ovr_d;
      tcnt_q      <= tcnt_d;
    end
  end

endmodule

// File: doc/hpm_window_sampler.md
HPM_WINDOW_SAMPLER -- requirements
Module: hpm_window_sampler

Interface
REQ-001 SHALL have parameter WINDOW_CYCLES, default 1000: sampling window length in clk_h cycles, legal range 4..2^32-1.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16: maximum wait for endD after a request, legal range 2..255.
REQ-003 SHALL have port clk_h, input, 1: clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_h, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port en, input, 1: monitoring enable.
REQ-006 SHALL have port hpm_raw, input, [1:0][63:0]: free-running event counters (index 0 = IMISS, index 1 = JMP_STALL).
REQ-007 SHALL have port HPM, output, [1:0][63:0]: per-window event deltas presented to the detector.
REQ-008 SHALL have port enableD, output, 1: analysis request pulse to the detector.
REQ-009 SHALL have port endD, input, 1: detector done; alert is valid in the same cycle.
REQ-010 SHALL have port alert, input, 2: detector class (00 legit, 10 stack overflow, 11 heap overflow, 01 reserved).
REQ-011 SHALL have port alert_q, output, 2: last captured class.
REQ-012 SHALL have port irq, output, 1: attack interrupt, level, sticky until acknowledged.
REQ-013 SHALL have port irq_ack, input, 1: clears irq.
REQ-014 SHALL have port attack_cnt, output, 32: count of non-legit verdicts.
REQ-015 SHALL have port timeout_err, output, 1: sticky flag, no endD received within TIMEOUT_CYCLES.
REQ-016 SHALL have port overrun_err, output, 1: sticky flag, a window expired while an analysis was pending.

Function
REQ-017 SHALL implement FSM states IDLE, COUNT, REQ, WAIT.
- IDLE -> COUNT when en=1; on this transition, base[i] <= hpm_raw[i] and the window counter <= 0.
REQ-018 SHALL count the window only in non-IDLE states; at count WINDOW_CYCLES-1 the counter wraps to 0 and a window end occurs.
REQ-019 At a window end in COUNT, SHALL register HPM[i] <= hpm_raw[i] - base[i] (modulo 2^64, so counter wrap-around yields the correct delta), set base[i] <= hpm_raw[i], and go to REQ.
REQ-020 In REQ, SHALL drive enableD=1 for exactly one cycle, then go to WAIT.
- enableD SHALL never be high for two consecutive cycles.
REQ-021 HPM SHALL stay stable from the REQ cycle until the WAIT exit.
REQ-022 In WAIT with endD=1, SHALL capture alert_q <= alert and return to COUNT.
- If alert != 00: irq <= 1, and attack_cnt increments, saturating at 32'hFFFFFFFF.
REQ-023 In WAIT, if endD has not arrived after TIMEOUT_CYCLES cycles, SHALL set timeout_err, leave alert_q unchanged, and return to COUNT.
REQ-024 On a window end in REQ or WAIT, SHALL update base, leave HPM unchanged, set overrun_err, and issue no extra request.
REQ-025 If endD=1 and a window end coincide in WAIT, SHALL capture the verdict and treat the window end as an overrun.
REQ-026 SHALL ignore endD outside WAIT.
REQ-027 When en=0 in any state, SHALL go to IDLE next cycle, force enableD=0, and keep alert_q, attack_cnt and the sticky flags.
REQ-028 irq_ack=1 SHALL clear irq; if a new attack capture occurs in the same cycle, the set wins.
REQ-029 timeout_err and overrun_err SHALL clear only on reset.
REQ-030 Latency: enableD SHALL assert 1 cycle after a window end; alert_q and irq SHALL update 1 cycle after endD.

Reset
REQ-031 While rst_h=0, SHALL hold: state IDLE, HPM=0, base=0, window counter=0, enableD=0, alert_q=00, irq=0, attack_cnt=0, timeout_err=0, overrun_err=0.
REQ-032 Reset asserted mid-WAIT SHALL abort immediately; no capture is performed after release.

Structure
REQ-033 SHALL place in shared package diwall_pkg:
- the state enum;
- alert class constants ALERT_LEG=2'b00, ALERT_SBO=2'b10, ALERT_HBO=2'b11;
- the HPM array width constant (64) and the event count (2).
REQ-034 SHALL contain one sub-module, diwall_window_timer, holding the window counter and window-end pulse; all other logic stays in the top module.

Verification
REQ-035 WINDOW_CYCLES=8, hpm_raw[0] +10 per cycle from 100, hpm_raw[1] constant 0 -> first enableD 9 cycles after en rises; HPM[0]=80, HPM[1]=0.
REQ-036 base=64'hFFFF_FFFF_FFFF_FFF0, raw=64'h10 at window end -> HPM=64'h20.
REQ-037 Detector model returns endD with alert=11 two cycles after enableD -> alert_q=11, irq=1, attack_cnt=1; irq_ack and a second attack in the same cycle -> irq stays 1, attack_cnt=2.
REQ-038 endD never returned, TIMEOUT_CYCLES=16 -> timeout_err=1 after 16 WAIT cycles; next window produces a new enableD.
REQ-039 WINDOW_CYCLES=4, endD delayed 6 cycles -> overrun_err=1, exactly one enableD per completed analysis.
REQ-040 rst_h low during WAIT, later endD=1 with alert=10 -> all outputs stay at reset values, no capture.
